// File: rtl/diff_frame_pkg.sv
// Shared types and constants for the frame-difference memory scheduler.
package diff_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_BURST = 2'd2
    } sched_state_e;

    typedef logic [1:0] bank_t;

    localparam logic [2:0] GNT_NONE = 3'b000;
    localparam logic [2:0] GNT_WR   = 3'b001;
    localparam logic [2:0] GNT_RD0  = 3'b010;
    localparam logic [2:0] GNT_RD1  = 3'b100;

    // First of wr+1, wr+2, wr+3 that does not collide with a bank being read.
    function automatic bank_t next_free_bank(input bank_t wr_b, input bank_t cur_b,
                                             input bank_t next_b, input logic guard);
        bank_t cand;
        bank_t pick;
        pick = wr_b + 2'd1;
        for (int i = 3; i >= 1; i--) begin
            cand = wr_b + bank_t'(i);
            if (!guard || ((cand != cur_b) && (cand != next_b))) begin
                pick = cand;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fb_bank_rotator.sv
// Frame-buffer bank bookkeeping: writer bank, last two complete frames, reader pair.
module fb_bank_rotator
    import diff_frame_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  cam_apply,
    input  logic  proc_apply,
    input  logic  frame_full,
    output bank_t wr_bank,
    output bank_t cur_bank,
    output bank_t next_bank,
    output logic  pair_valid,
    output logic  frame_drop
);

    bank_t       wr_bank_r, cur_bank_r, next_bank_r, newest_r, older_r;
    bank_t       wr_bank_s, cur_bank_s, next_bank_s, newest_s, older_s;
    logic [1:0]  done_cnt_r, done_cnt_s;
    logic        pair_valid_r, pair_valid_s, frame_drop_r, frame_drop_s;

    // Camera event first, then processing event sees the updated newest/older.
    always_comb begin
        wr_bank_s    = wr_bank_r;
        cur_bank_s   = cur_bank_r;
        next_bank_s  = next_bank_r;
        newest_s     = newest_r;
        older_s      = older_r;
        done_cnt_s   = done_cnt_r;
        pair_valid_s = pair_valid_r;
        frame_drop_s = 1'b0;
        if (cam_apply) begin
            if (frame_full) begin
                older_s    = newest_r;
                newest_s   = wr_bank_r;
                done_cnt_s = (done_cnt_r == 2'd2) ? 2'd2 : done_cnt_r + 2'd1;
            end else begin
                frame_drop_s = 1'b1;
            end
            wr_bank_s = next_free_bank(wr_bank_r, cur_bank_r, next_bank_r, pair_valid_r);
        end else begin
            frame_drop_s = 1'b0;
        end
        if (proc_apply) begin
            next_bank_s  = newest_s;
            cur_bank_s   = older_s;
            pair_valid_s = (done_cnt_s == 2'd2);
        end else begin
            pair_valid_s = pair_valid_r;
        end
    end

    // Bank state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_r    <= 2'd0;
            cur_bank_r   <= 2'd0;
            next_bank_r  <= 2'd0;
            newest_r     <= 2'd0;
            older_r      <= 2'd0;
            done_cnt_r   <= 2'd0;
            pair_valid_r <= 1'b0;
            frame_drop_r <= 1'b0;
        end else begin
            wr_bank_r    <= wr_bank_s;
            cur_bank_r   <= cur_bank_s;
            next_bank_r  <= next_bank_s;
            newest_r     <= newest_s;
            older_r      <= older_s;
            done_cnt_r   <= done_cnt_s;
            pair_valid_r <= pair_valid_s;
            frame_drop_r <= frame_drop_s;
        end
    end

    assign wr_bank    = wr_bank_r;
    assign cur_bank   = cur_bank_r;
    assign next_bank  = next_bank_r;
    assign pair_valid = pair_valid_r;
    assign frame_drop = frame_drop_r;

endmodule

// File: rtl/diff_frame_sched.sv
// Burst-command scheduler sharing one memory port between the camera writer
// and the current/next-frame readers of the difference path.
module diff_frame_sched
    import diff_frame_pkg::*;
#(
    parameter int                ADDR_W       = 24,
    parameter int                BURST_LEN    = 256,
    parameter int                FRAME_BURSTS = 1200,
    parameter logic [ADDR_W-1:0] BANK_STRIDE  = 24'h080000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cam_vsync,
    input  logic              proc_vsync,
    input  logic              wr_req,
    input  logic              rd0_req,
    input  logic              rd1_req,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_wr,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    input  logic              mem_done,
    output logic [2:0]        grant,
    output bank_t             wr_bank,
    output bank_t             cur_bank,
    output bank_t             next_bank,
    output logic              pair_valid,
    output logic              frame_drop
);

    localparam int             CNT_W    = $clog2(FRAME_BURSTS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BURSTS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    function automatic logic [ADDR_W-1:0] burst_addr(input bank_t bank, input logic [CNT_W-1:0] cnt);
        return ADDR_W'(bank) * BANK_STRIDE + ADDR_W'(cnt) * ADDR_W'(BURST_LEN);
    endfunction

    sched_state_e      state_r;
    logic              cam_prev_r, proc_prev_r, cam_pend_r, proc_pend_r, last_rd0_r;
    logic [CNT_W-1:0]  wr_cnt_r, rd0_cnt_r, rd1_cnt_r;
    logic              cmd_valid_r, cmd_wr_r;
    logic [ADDR_W-1:0] cmd_addr_r;
    logic [2:0]        grant_r;

    logic              idle_s, cam_apply_s, proc_apply_s;
    logic              wr_elig_s, rd0_elig_s, rd1_elig_s;
    logic [2:0]        sel_grant_s;
    bank_t             sel_bank_s;
    logic [CNT_W-1:0]  sel_cnt_s;
    logic [ADDR_W-1:0] sel_addr_s;

    assign idle_s       = (state_r == ST_IDLE);
    assign cam_apply_s  = idle_s && cam_pend_r;
    assign proc_apply_s = idle_s && proc_pend_r;
    assign wr_elig_s    = wr_req && (wr_cnt_r < CNT_MAX);
    assign rd0_elig_s   = rd0_req && pair_valid && (rd0_cnt_r < CNT_MAX);
    assign rd1_elig_s   = rd1_req && pair_valid && (rd1_cnt_r < CNT_MAX);
    assign sel_addr_s   = burst_addr(sel_bank_s, sel_cnt_s);

    fb_bank_rotator u_rotator (
        .clk        (clk),
        .rst_n      (rst_n),
        .cam_apply  (cam_apply_s),
        .proc_apply (proc_apply_s),
        .frame_full (wr_cnt_r == CNT_MAX),
        .wr_bank    (wr_bank),
        .cur_bank   (cur_bank),
        .next_bank  (next_bank),
        .pair_valid (pair_valid),
        .frame_drop (frame_drop)
    );

    // Write wins outright; on a read tie the read not served last goes next.
    always_comb begin
        sel_grant_s = GNT_NONE;
        sel_bank_s  = wr_bank;
        sel_cnt_s   = wr_cnt_r;
        if (wr_elig_s) begin
            sel_grant_s = GNT_WR;
        end else if (rd0_elig_s && (!rd1_elig_s || !last_rd0_r)) begin
            sel_grant_s = GNT_RD0;
            sel_bank_s  = cur_bank;
            sel_cnt_s   = rd0_cnt_r;
        end else if (rd1_elig_s) begin
            sel_grant_s = GNT_RD1;
            sel_bank_s  = next_bank;
            sel_cnt_s   = rd1_cnt_r;
        end else begin
            sel_grant_s = GNT_NONE;
        end
    end

    // Vsync capture, command FSM and per-requester burst counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cam_prev_r  <= 1'b0;
            proc_prev_r <= 1'b0;
            cam_pend_r  <= 1'b0;
            proc_pend_r <= 1'b0;
            last_rd0_r  <= 1'b0;
            wr_cnt_r    <= CNT_ZERO;
            rd0_cnt_r   <= CNT_ZERO;
            rd1_cnt_r   <= CNT_ZERO;
            cmd_valid_r <= 1'b0;
            cmd_wr_r    <= 1'b0;
            cmd_addr_r  <= {ADDR_W{1'b0}};
            grant_r     <= GNT_NONE;
        end else begin
            cam_prev_r  <= cam_vsync;
            proc_prev_r <= proc_vsync;
            cam_pend_r  <= (cam_vsync && !cam_prev_r) || (cam_pend_r && !cam_apply_s);
            proc_pend_r <= (proc_vsync && !proc_prev_r) || (proc_pend_r && !proc_apply_s);
            case (state_r)
                ST_IDLE: begin
                    if (cam_pend_r || proc_pend_r) begin
                        if (cam_apply_s) wr_cnt_r <= CNT_ZERO;
                        if (proc_apply_s) begin
                            rd0_cnt_r <= CNT_ZERO;
                            rd1_cnt_r <= CNT_ZERO;
                        end
                    end else if (sel_grant_s != GNT_NONE) begin
                        state_r     <= ST_CMD;
                        cmd_valid_r <= 1'b1;
                        cmd_wr_r    <= (sel_grant_s == GNT_WR);
                        cmd_addr_r  <= sel_addr_s;
                        grant_r     <= sel_grant_s;
                        if (sel_grant_s == GNT_RD0) last_rd0_r <= 1'b1;
                        else if (sel_grant_s == GNT_RD1) last_rd0_r <= 1'b0;
                    end
                end
                ST_CMD: begin
                    if (mem_cmd_ready) begin
                        cmd_valid_r <= 1'b0;
                        state_r     <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (mem_done) begin
                        state_r <= ST_IDLE;
                        grant_r <= GNT_NONE;
                        if (grant_r == GNT_WR) wr_cnt_r <= wr_cnt_r + CNT_ONE;
                        else if (grant_r == GNT_RD0) rd0_cnt_r <= rd0_cnt_r + CNT_ONE;
                        else if (grant_r == GNT_RD1) rd1_cnt_r <= rd1_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cmd_valid_r <= 1'b0;
                    grant_r     <= GNT_NONE;
                end
            endcase
        end
    end

    assign mem_cmd_valid = cmd_valid_r;
    assign mem_cmd_wr    = cmd_wr_r;
    assign mem_cmd_addr  = cmd_addr_r;
    assign grant         = grant_r;

endmodule

// File: tb/tb_diff_frame_sched.sv
// Directed bench for diff_frame_sched with a 4-word burst, 3-burst frame, stride 16.
module tb_diff_frame_sched;
    import diff_frame_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, cam_vsync, proc_vsync, wr_req, rd0_req, rd1_req;
    logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_wr, mem_done;
    logic [23:0] mem_cmd_addr;
    logic [2:0]  grant;
    bank_t       wr_bank, cur_bank, next_bank;
    logic        pair_valid, frame_drop;

    int n_vec = 0;
    int n_err = 0;

    diff_frame_sched #(
        .ADDR_W(24), .BURST_LEN(4), .FRAME_BURSTS(3), .BANK_STRIDE(24'd16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .proc_vsync(proc_vsync),
        .wr_req(wr_req), .rd0_req(rd0_req), .rd1_req(rd1_req),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_wr(mem_cmd_wr), .mem_cmd_addr(mem_cmd_addr), .mem_done(mem_done),
        .grant(grant), .wr_bank(wr_bank), .cur_bank(cur_bank), .next_bank(next_bank),
        .pair_valid(pair_valid), .frame_drop(frame_drop)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Act as the memory for one burst: wait for the command, check it, optionally
    // stall ready (with a spurious early done and optional vsyncs), then complete.
    task automatic serve(input string tag, input logic [2:0] exp_gnt, input logic exp_wr,
                         input logic [23:0] exp_addr, input int hold, input bit mid_vs);
        int waited = 0;
        while (!mem_cmd_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_val({tag, "_valid"}, 32'(mem_cmd_valid), 32'd1);
        check_val({tag, "_grant"}, 32'(grant), 32'(exp_gnt));
        check_val({tag, "_wr"}, 32'(mem_cmd_wr), 32'(exp_wr));
        check_val({tag, "_addr"}, 32'(mem_cmd_addr), 32'(exp_addr));
        for (int i = 0; i < hold; i++) begin
            if (mid_vs) begin
                cam_vsync  = (i == 0);
                proc_vsync = (i == 0);
            end
            mem_done = (i == 1);
            @(negedge clk);
            check_val({tag, "_hold_valid"}, 32'(mem_cmd_valid), 32'd1);
            check_val({tag, "_hold_addr"}, 32'(mem_cmd_addr), 32'(exp_addr));
        end
        cam_vsync     = 1'b0;
        proc_vsync    = 1'b0;
        mem_done      = 1'b0;
        mem_cmd_ready = 1'b1;
        @(negedge clk);
        mem_cmd_ready = 1'b0;
        check_val({tag, "_vdrop"}, 32'(mem_cmd_valid), 32'd0);
        check_val({tag, "_ghold"}, 32'(grant), 32'(exp_gnt));
        @(negedge clk);
        mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
        check_val({tag, "_gclr"}, 32'(grant), 32'd0);
    endtask

    task automatic expect_idle(input string tag, input int n);
        logic seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (mem_cmd_valid) seen = 1'b1;
        end
        check_val(tag, 32'(seen), 32'd0);
    endtask

    task automatic vs_pulse(input bit cam, input bit proc);
        cam_vsync  = cam;
        proc_vsync = proc;
        @(negedge clk);
        cam_vsync  = 1'b0;
        proc_vsync = 1'b0;
        @(negedge clk);
    endtask

    task automatic cam_check(input string tag, input logic exp_drop, input bank_t exp_wr);
        vs_pulse(1'b1, 1'b0);
        check_val({tag, "_drop"}, 32'(frame_drop), 32'(exp_drop));
        check_val({tag, "_wrbank"}, 32'(wr_bank), 32'(exp_wr));
        @(negedge clk);
        check_val({tag, "_drop_end"}, 32'(frame_drop), 32'd0);
    endtask

    task automatic proc_check(input string tag, input bank_t exp_cur, input bank_t exp_next,
                              input logic exp_pair);
        vs_pulse(1'b0, 1'b1);
        check_val({tag, "_cur"}, 32'(cur_bank), 32'(exp_cur));
        check_val({tag, "_next"}, 32'(next_bank), 32'(exp_next));
        check_val({tag, "_pair"}, 32'(pair_valid), 32'(exp_pair));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cam_vsync = 1'b0; proc_vsync = 1'b0;
        wr_req = 1'b0; rd0_req = 1'b0; rd1_req = 1'b0;
        mem_cmd_ready = 1'b0; mem_done = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_valid", 32'(mem_cmd_valid), 32'd0);
        check_val("rst_wr", 32'(mem_cmd_wr), 32'd0);
        check_val("rst_addr", 32'(mem_cmd_addr), 32'd0);
        check_val("rst_grant", 32'(grant), 32'd0);
        check_val("rst_banks", 32'({wr_bank, cur_bank, next_bank}), 32'd0);
        check_val("rst_pair", 32'(pair_valid), 32'd0);
        check_val("rst_drop", 32'(frame_drop), 32'd0);
        rst_n = 1'b1;

        // Two complete frames into banks 0 and 1.
        wr_req = 1'b1;
        serve("w0", GNT_WR, 1'b1, 24'd0, 0, 1'b0);
        serve("w1", GNT_WR, 1'b1, 24'd4, 0, 1'b0);
        serve("w2", GNT_WR, 1'b1, 24'd8, 0, 1'b0);
        expect_idle("wr_sat", 4);
        cam_check("cam1", 1'b0, 2'd1);
        check_val("cam1_pair", 32'(pair_valid), 32'd0);
        serve("w3", GNT_WR, 1'b1, 24'd16, 0, 1'b0);
        serve("w4", GNT_WR, 1'b1, 24'd20, 0, 1'b0);
        serve("w5", GNT_WR, 1'b1, 24'd24, 0, 1'b0);
        wr_req = 1'b0;
        cam_check("cam2", 1'b0, 2'd2);
        check_val("cam2_pair", 32'(pair_valid), 32'd0);
        proc_check("proc1", 2'd0, 2'd1, 1'b1);

        // Reads round-robin, then write priority against rd0.
        rd0_req = 1'b1; rd1_req = 1'b1;
        serve("r0a", GNT_RD0, 1'b0, 24'd0, 0, 1'b0);
        serve("r1a", GNT_RD1, 1'b0, 24'd16, 0, 1'b0);
        serve("r0b", GNT_RD0, 1'b0, 24'd4, 0, 1'b0);
        serve("r1b", GNT_RD1, 1'b0, 24'd20, 0, 1'b0);
        wr_req = 1'b1; rd1_req = 1'b0;
        serve("wpri", GNT_WR, 1'b1, 24'd32, 0, 1'b0);
        wr_req = 1'b0;
        serve("r0c", GNT_RD0, 1'b0, 24'd8, 0, 1'b0);
        rd1_req = 1'b1;
        serve("r1c", GNT_RD1, 1'b0, 24'd24, 0, 1'b0);
        expect_idle("rd_sat", 4);
        rd0_req = 1'b0; rd1_req = 1'b0;

        // Incomplete frame in bank 2 is dropped; bank 3 is the only free one.
        wr_req = 1'b1;
        serve("wd", GNT_WR, 1'b1, 24'd36, 0, 1'b0);
        wr_req = 1'b0;
        cam_check("drop1", 1'b1, 2'd3);
        check_val("drop1_newest", 32'(dut.u_rotator.newest_r), 32'd1);
        check_val("drop1_older", 32'(dut.u_rotator.older_r), 32'd0);

        // Build pair cur=1/next=2 with writer on bank 0, then rotate around it.
        cam_check("drop2", 1'b1, 2'd2);
        wr_req = 1'b1;
        serve("w6", GNT_WR, 1'b1, 24'd32, 0, 1'b0);
        serve("w7", GNT_WR, 1'b1, 24'd36, 0, 1'b0);
        serve("w8", GNT_WR, 1'b1, 24'd40, 0, 1'b0);
        wr_req = 1'b0;
        cam_check("cam3", 1'b0, 2'd3);
        proc_check("proc2", 2'd1, 2'd2, 1'b1);
        cam_check("rot0", 1'b1, 2'd0);
        cam_check("rot1", 1'b1, 2'd3);
        cam_check("rot2", 1'b1, 2'd0);

        // Both vsyncs during a stalled burst apply together, cam before proc.
        wr_req = 1'b1;
        serve("w9", GNT_WR, 1'b1, 24'd0, 0, 1'b0);
        serve("w10", GNT_WR, 1'b1, 24'd4, 0, 1'b0);
        serve("wmid", GNT_WR, 1'b1, 24'd8, 5, 1'b1);
        @(negedge clk);
        check_val("mid_noval", 32'(mem_cmd_valid), 32'd0);
        check_val("mid_cur", 32'(cur_bank), 32'd2);
        check_val("mid_next", 32'(next_bank), 32'd0);
        check_val("mid_wrbank", 32'(wr_bank), 32'd3);
        check_val("mid_pair", 32'(pair_valid), 32'd1);
        check_val("mid_drop", 32'(frame_drop), 32'd0);
        serve("w11", GNT_WR, 1'b1, 24'd48, 0, 1'b0);
        wr_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/diff_frame_sched.md
# diff_frame_sched

Memory-access scheduler for the frame-difference path. It owns a 4-bank frame buffer and sequences one shared burst-memory command port between three requesters: the camera write FIFO and the two read FIFOs that supply the current and next frame pixels to the difference datapath. It rotates the banks on camera and processing vsync so the difference stage always reads two consecutive, fully written frames that the writer never overwrites.

## Interface
- `ADDR_W`, 24: memory word-address width.
- `BURST_LEN`, 256: words per burst.
- `FRAME_BURSTS`, 1200: bursts per frame (640×480 / 256).
- `BANK_STRIDE`, 24'h080000: address distance between banks.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cam_vsync` in 1: camera frame sync, synchronous to `clk`; rising edge marks a frame boundary.
- `proc_vsync` in 1: difference-path frame sync; rising edge marks a frame boundary.
- `wr_req` in 1: write FIFO holds ≥ `BURST_LEN` words.
- `rd0_req` in 1: current-frame read FIFO has room for ≥ `BURST_LEN` words.
- `rd1_req` in 1: next-frame read FIFO has room for ≥ `BURST_LEN` words.
- `mem_cmd_valid` out 1: command valid.
- `mem_cmd_ready` in 1: memory accepts the command.
- `mem_cmd_wr` out 1: 1 = write burst, 0 = read burst.
- `mem_cmd_addr` out `ADDR_W`: burst start address.
- `mem_done` in 1: one-cycle pulse at the end of a burst.
- `grant` out 3: one-hot {rd1, rd0, wr}; routes the FIFO data path.
- `wr_bank`, `cur_bank`, `next_bank` out 2: active banks.
- `pair_valid` out 1: the read banks hold two complete consecutive frames.
- `frame_drop` out 1: one-cycle pulse when an incomplete write frame is discarded.

## Operation
- **Vsync edge detection:** one register per vsync. A rise sets the matching pending flag (`cam_pend`, `proc_pend`).
- **FSM states:** IDLE, CMD, BURST.
  - IDLE applies the pending events, then arbitrates.
  - CMD drives valid and holds it until ready.
  - BURST waits for `mem_done`, then returns to IDLE.
- **cam_pend application:**
  - If `wr_cnt == FRAME_BURSTS`: `older` ← `newest`, `newest` ← `wr_bank`, and `done_cnt` increments, saturating at 2.
  - Otherwise pulse `frame_drop` and leave `newest`/`older` unchanged.
  - Then `wr_bank` ← the first of `wr_bank`+1, +2, +3 (mod 4) that is not `cur_bank`/`next_bank` while `pair_valid`=1.
  - `wr_cnt` ← 0.
- **proc_pend application:** `next_bank` ← `newest`, `cur_bank` ← `older`, `pair_valid` ← (`done_cnt` == 2), `rd0_cnt` = `rd1_cnt` ← 0.
- **Both pending in the same IDLE cycle:** cam applies first, and proc uses the updated `newest`/`older`.
- **Eligibility:**
  - `wr`: `wr_req` && `wr_cnt` < `FRAME_BURSTS`.
  - `rdN`: `rdN_req` && `pair_valid` && `rdN_cnt` < `FRAME_BURSTS`.
- **Arbitration:** evaluated only in an IDLE cycle with no pending flags. Write has strict priority. rd0/rd1 round-robin, and the last-served read loses ties.
- **Address:** bank × `BANK_STRIDE` + cnt × `BURST_LEN`, computed in `ADDR_W` bits with no overflow check. The bank is `wr_bank`, `cur_bank` (rd0) or `next_bank` (rd1).
- **Counter update:** the granted counter increments on `mem_done`.
- **Vsync during CMD/BURST:** only sets the pending flag. The burst in flight completes against its latched bank and address.
- **Counter saturation:** at `FRAME_BURSTS` the requester stays ineligible until its vsync.

## Timing
- **Reset values:** state IDLE; `mem_cmd_valid`=0, `mem_cmd_wr`=0, `mem_cmd_addr`=0, `grant`=0, `wr_bank`=0, `cur_bank`=0, `next_bank`=0, `pair_valid`=0, `frame_drop`=0. All counters and pending flags are 0; `newest`=0, `older`=0, `done_cnt`=0.
- Reset mid-burst aborts immediately to reset values.
- **Vsync path:** vsync rise at cycle t → pending set at t+1 → applied in the first IDLE cycle ≥ t+1.
- **Command path:** arbitration in an IDLE cycle at t → CMD from t+1, with `mem_cmd_valid`, `mem_cmd_wr`, `mem_cmd_addr` and `grant` registered.
- **Handshake:** `mem_cmd_valid` drops the cycle after valid && ready. Address, wr flag and grant are stable while valid.
- **Grant:** held from CMD entry through the `mem_done` cycle, and 0 the following cycle (IDLE).
- **Throughput and turnaround:** one IDLE cycle minimum between bursts. `mem_done` before ready is ignored.

## Structure
- **Package `diff_frame_pkg`:** FSM state enum; grant one-hot constants `GNT_WR`, `GNT_RD0`, `GNT_RD1`; bank-index type (2 bits).
- **Sub-module `fb_bank_rotator`:** `wr_bank`/`newest`/`older`/`cur`/`next` selection, `done_cnt`, `frame_drop`. The scheduler instantiates it and feeds it the pending-apply strobes.

## Test plan
Bench parameters: `BURST_LEN`=4, `FRAME_BURSTS`=3, `BANK_STRIDE`=16.
- Reset, then hold `wr_req`=1 with a cam vsync rise every 20 cycles → write addresses 0, 4, 8, then 16, 20, 24. `frame_drop`=0 and `pair_valid` stays 0 until two cam rises followed by a proc rise.
- Two full frames written (banks 0 and 1), then a proc rise → `cur_bank`=0, `next_bank`=1, `pair_valid`=1. With `rd0_req`=`rd1_req`=1, grants alternate rd0 (address 0), rd1 (address 16), rd0 (address 4), …
- `wr_req` and `rd0_req` asserted in the same IDLE cycle → `grant`=001 first, and the rd0 burst issues after `mem_done`.
- Cam rise after only 2 write bursts → `frame_drop` pulses for 1 cycle, `newest`/`older` are unchanged and `wr_bank` advances.
- With `pair_valid`=1, `cur_bank`=1, `next_bank`=2 and `wr_bank`=0, two cam rises → `wr_bank` goes 0→3, then 3→0; it never enters 1 or 2.
- Cam and proc rises while a burst is outstanding, with `mem_cmd_ready` held low for 5 cycles → the command address is stable throughout. After `mem_done`, both events apply in one IDLE cycle, with cam applied before proc.
